cmp_serial_1_1: RTL and testbench
=================================

// Module: cmp_serial_1_1
//
// PURPOSE
//   Bit-serial magnitude comparator cell: the sequential counterpart of the
//   parallel CMP_1_1 primitive. Receives operands A and B one bit per cycle
//   and reports EQ/INEQ/GT/LT with the same meaning as CMP_1_1.
//   Used by synthesis when an always-block comparison is mapped onto
//   serialized datapaths (always/seq flow) instead of a wide parallel CMP.
//
// PARAMETERS
//   WIDTH      8   operand width in bits (>=1)
//   MSB_FIRST  1   1: bit stream is MSB first; 0: LSB first
//   SIGNED     0   1: operands are two's complement; 0: unsigned
//
// PORTS
//   CLK    in   1                  clock, all state updates on rising edge
//   RST    in   1                  synchronous reset, active-high
//   START  in   1                  begin a new comparison (pulse)
//   VALID  in   1                  A/B carry a valid operand bit this cycle
//   A      in   1                  serial operand A bit
//   B      in   1                  serial operand B bit
//   BUSY   out  1                  comparison in progress (state RUN)
//   DONE   out  1                  one-cycle pulse: result registers just updated
//   EQ     out  1                  A == B
//   INEQ   out  1                  A != B
//   GT     out  1                  A >  B
//   LT     out  1                  A <  B
//   CNT    out  $clog2(WIDTH+1)    bits consumed in current comparison
//
// BEHAVIOUR
//   Reset (RST=1 at edge, any state): state IDLE; BUSY,DONE,EQ,INEQ,GT,LT=0;
//     CNT=0; internal decision cleared. RST wins over every other input.
//   States: IDLE -> RUN -> FIN -> IDLE. All outputs registered.
//   IDLE: START=1 -> RUN, CNT=0, decision=EQUAL. VALID ignored in IDLE.
//   RUN: BUSY=1. VALID=1 consumes A,B, CNT+=1; VALID=0 stalls, no change.
//     MSB_FIRST=1: first differing bit fixes decision; later bits consumed
//       but do not change it.
//     MSB_FIRST=0: every differing bit overwrites decision (last wins).
//     Differing bit: A=1,B=0 -> GT; A=0,B=1 -> LT.
//     SIGNED=1: on the sign bit (first bit if MSB_FIRST, WIDTH-th bit
//       otherwise) the polarity is inverted: A=1,B=0 -> LT; A=0,B=1 -> GT.
//     When the WIDTH-th bit is consumed -> FIN.
//   FIN (one cycle): DONE=1, BUSY=0; EQ/INEQ/GT/LT take final decision,
//     visible in this same cycle (latency 1 cycle after last bit).
//     Next state IDLE.
//   Result outputs hold their value until the next FIN or RST; they are
//     not cleared by START. When valid, exactly one of EQ/GT/LT is 1 and
//     INEQ = ~EQ. Before the first completed comparison all four are 0.
//   START in RUN: abort, restart (CNT=0, decision=EQUAL); the A/B bits of
//     that cycle are NOT consumed even if VALID=1.
//   START in FIN: accepted -> RUN; DONE still pulses that cycle.
//   START and VALID together in IDLE: START taken, bit discarded.
//   WIDTH=1: single bit is both first and sign bit.
//
// TESTING
//   1. WIDTH=8,MSB_FIRST=1,unsigned: A=0xA5,B=0xA4 streamed back-to-back ->
//      DONE 1 cycle after 8th bit, GT=1,INEQ=1,EQ=0,LT=0, CNT=8 at FIN.
//   2. Same, A=B=0x3C with VALID gaps of 0..3 cycles -> EQ=1 after 8 valid
//      bits exactly; BUSY high throughout, DONE single-cycle.
//   3. MSB_FIRST=0,unsigned: A=0x81,B=0x7F LSB first -> GT=1 (bit 7 decides
//      over bit 1 difference).
//   4. SIGNED=1,MSB_FIRST=1: A=0x80(-128),B=0x01 -> LT=1; A=0xFF(-1),B=0xFE
//      (-2) -> GT=1.
//   5. START after 4 bits of A=0x00,B=0xFF, then stream A=0x10,B=0x10 ->
//      EQ=1; CNT reset to 0 on restart.
//   6. RST asserted mid-RUN (CNT=5) -> next cycle BUSY=0,DONE=0,EQ/GT/LT/INEQ
//      all 0, CNT=0; following full comparison completes normally.

Source files
------------

// File: rtl/cmp_serial_1_1.sv
// Bit-serial magnitude comparator: consumes one A/B bit pair per valid cycle and
// reports EQ/INEQ/GT/LT once WIDTH bits have been seen.
//
// Handshake: there is no backpressure. A bit pair is consumed on a rising edge
// only when the state is RUN, i_valid=1 and i_start=0. i_start is honoured in
// every state and always wins over i_valid.
module cmp_serial_1_1 #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit SIGNED    = 1'b0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic                       i_valid,
   input  logic                       i_a,
   input  logic                       i_b,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_eq,
   output logic                       o_ineq,
   output logic                       o_gt,
   output logic                       o_lt,
   output logic [$clog2(WIDTH+1)-1:0] o_cnt,
   output logic [1:0]                 o_state
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
   localparam logic [CW-1:0] SIGN_IDX = MSB_FIRST ? '0 : LAST;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;
   typedef enum logic [1:0] {D_EQ = 2'd0, D_GT = 2'd1, D_LT = 2'd2} dec_t;

   state_t          r_state, w_state_nx;
   dec_t            r_dec, w_dec_nx, w_dec_bit;
   logic [CW-1:0]   r_cnt, w_cnt_nx;
   logic            r_busy, r_done, r_eq, r_ineq, r_gt, r_lt;
   logic            w_is_sign, w_take;

   // Sign bit flips which operand is "larger" when the bits differ.
   always_comb begin
      w_is_sign = SIGNED && (r_cnt == SIGN_IDX);
      w_take    = !MSB_FIRST || (r_dec == D_EQ);
      w_dec_bit = r_dec;
      if ((i_a != i_b) && w_take) begin
         w_dec_bit = (i_a ^ w_is_sign) ? D_GT : D_LT;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_dec_nx   = r_dec;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nx = S_RUN;
               w_cnt_nx   = '0;
               w_dec_nx   = D_EQ;
            end
         end
         S_RUN: begin
            if (i_start) begin
               w_cnt_nx = '0;
               w_dec_nx = D_EQ;
            end else if (i_valid) begin
               w_cnt_nx = r_cnt + 1'b1;
               w_dec_nx = w_dec_bit;
               if (r_cnt == LAST) begin
                  w_state_nx = S_FIN;
               end
            end
         end
         S_FIN: begin
            if (i_start) begin
               w_state_nx = S_RUN;
               w_cnt_nx   = '0;
               w_dec_nx   = D_EQ;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dec   <= D_EQ;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_eq    <= 1'b0;
         r_ineq  <= 1'b0;
         r_gt    <= 1'b0;
         r_lt    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_dec   <= w_dec_nx;
         r_busy  <= (w_state_nx == S_RUN);
         r_done  <= (w_state_nx == S_FIN);
         // Results load only on entry to FIN and hold otherwise.
         if (w_state_nx == S_FIN) begin
            r_eq   <= (w_dec_nx == D_EQ);
            r_ineq <= (w_dec_nx != D_EQ);
            r_gt   <= (w_dec_nx == D_GT);
            r_lt   <= (w_dec_nx == D_LT);
         end
      end
   end

   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_eq    = r_eq;
   assign o_ineq  = r_ineq;
   assign o_gt    = r_gt;
   assign o_lt    = r_lt;
   assign o_cnt   = r_cnt;
   assign o_state = r_state;

endmodule

// File: tb/tb_cmp_serial_1_1.sv
// Bench for cmp_serial_1_1: four 8-bit instances (MSB/LSB first x unsigned/signed)
// fed the same operands, checked against integer comparison of the whole operands.
module tb_cmp_serial_1_1;

   logic clk = 1'b0;
   logic rst, start, valid;
   logic a_msb, b_msb, a_lsb, b_lsb;

   logic [3:0] w_busy, w_done, w_eq, w_ineq, w_gt, w_lt;
   logic [3:0] w_cnt [4];
   logic [1:0] w_state [4];

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] hold_res;

   always #5 clk = ~clk;

   // Instance k: k[0]=0 -> MSB first, k[1]=1 -> signed.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam bit MSB = (g % 2 == 0);
      localparam bit SGN = (g / 2 == 1);
      cmp_serial_1_1 #(.WIDTH(8), .MSB_FIRST(MSB), .SIGNED(SGN)) dut (
         .i_clk   (clk),
         .i_rst   (rst),
         .i_start (start),
         .i_valid (valid),
         .i_a     (MSB ? a_msb : a_lsb),
         .i_b     (MSB ? b_msb : b_lsb),
         .o_busy  (w_busy[g]),
         .o_done  (w_done[g]),
         .o_eq    (w_eq[g]),
         .o_ineq  (w_ineq[g]),
         .o_gt    (w_gt[g]),
         .o_lt    (w_lt[g]),
         .o_cnt   (w_cnt[g]),
         .o_state (w_state[g])
      );
   end

   // Expected {eq,ineq,gt,lt} from whole-operand integer comparison.
   function automatic logic [3:0] ref_cmp(logic [7:0] a, logic [7:0] b, bit sgn);
      int ia, ib;
      ia = sgn ? int'($signed(a)) : int'(a);
      ib = sgn ? int'($signed(b)) : int'(b);
      return {ia == ib, ia != ib, ia > ib, ia < ib};
   endfunction

   function automatic logic [15:0] ref_all(logic [7:0] a, logic [7:0] b);
      return {ref_cmp(a, b, 1'b1), ref_cmp(a, b, 1'b1),
              ref_cmp(a, b, 1'b0), ref_cmp(a, b, 1'b0)};
   endfunction

   function automatic logic [15:0] dut_res();
      logic [15:0] r;
      for (int k = 0; k < 4; k++) r[4*k +: 4] = {w_eq[k], w_ineq[k], w_gt[k], w_lt[k]};
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(string tag, int exp);
      for (int k = 0; k < 4; k++) chk(tag, 32'(w_cnt[k]), 32'(exp));
   endtask

   // Pulses START; with junk=1 a random valid bit pair rides along and must be dropped.
   task automatic begin_cmp(logic [7:0] a, logic [7:0] b, bit junk);
      exp_q.push_back(ref_all(a, b));
      start = 1'b1;
      valid = junk;
      a_msb = 1'($urandom_range(0, 1)); b_msb = 1'($urandom_range(0, 1));
      a_lsb = 1'($urandom_range(0, 1)); b_lsb = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      valid = 1'b0;
      chk("start_busy", 32'(w_busy), 32'hF);
      chk("start_done", 32'(w_done), 32'h0);
      chk_cnt("start_cnt", 0);
      chk("start_hold", 32'(dut_res()), 32'(hold_res));
   endtask

   task automatic send_bit(logic [7:0] a, logic [7:0] b, int idx, int max_gap);
      int gap;
      gap = $urandom_range(0, max_gap);
      for (int i = 0; i < gap; i++) begin
         valid = 1'b0;
         a_msb = 1'($urandom_range(0, 1)); b_msb = 1'($urandom_range(0, 1));
         a_lsb = 1'($urandom_range(0, 1)); b_lsb = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("stall_busy", 32'(w_busy), 32'hF);
         chk_cnt("stall_cnt", idx);
      end
      valid = 1'b1;
      a_msb = a[7-idx]; b_msb = b[7-idx];
      a_lsb = a[idx];   b_lsb = b[idx];
      @(negedge clk);
      valid = 1'b0;
      if (idx < 7) begin
         chk("run_busy", 32'(w_busy), 32'hF);
         chk("run_done", 32'(w_done), 32'h0);
         chk_cnt("run_cnt", idx + 1);
      end
   endtask

   task automatic run_bits(logic [7:0] a, logic [7:0] b, int max_gap);
      for (int i = 0; i < 8; i++) send_bit(a, b, i, max_gap);
   endtask

   task automatic check_fin(string tag);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_noexp"}, 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, "_done"}, 32'(w_done), 32'hF);
      chk({tag, "_busy"}, 32'(w_busy), 32'h0);
      chk_cnt({tag, "_cnt"}, 8);
      chk({tag, "_res"}, 32'(dut_res()), 32'(e));
      hold_res = e;
   endtask

   // Leaves FIN with stray valid bits present, then idles one more cycle.
   task automatic finish_idle(string tag);
      for (int i = 0; i < 2; i++) begin
         valid = 1'b1;
         a_msb = 1'($urandom_range(0, 1)); b_msb = 1'($urandom_range(0, 1));
         a_lsb = 1'($urandom_range(0, 1)); b_lsb = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk({tag, "_idle_done"}, 32'(w_done), 32'h0);
         chk({tag, "_idle_busy"}, 32'(w_busy), 32'h0);
         chk({tag, "_idle_hold"}, 32'(dut_res()), 32'(hold_res));
      end
      valid = 1'b0;
   endtask

   task automatic full_cmp(string tag, logic [7:0] a, logic [7:0] b, int max_gap);
      begin_cmp(a, b, 1'b0);
      run_bits(a, b, max_gap);
      check_fin(tag);
      finish_idle(tag);
   endtask

   initial begin
      logic [7:0] ra, rb;
      rst = 1'b1; start = 1'b0; valid = 1'b0;
      a_msb = 1'b0; b_msb = 1'b0; a_lsb = 1'b0; b_lsb = 1'b0;
      hold_res = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(w_busy), 32'h0);
      chk("rst_done", 32'(w_done), 32'h0);
      chk("rst_res", 32'(dut_res()), 32'h0);
      chk_cnt("rst_cnt", 0);
      rst = 1'b0;
      @(negedge clk);

      full_cmp("a5_a4", 8'hA5, 8'hA4, 0);
      full_cmp("eq_3c_gaps", 8'h3C, 8'h3C, 3);
      full_cmp("81_7f", 8'h81, 8'h7F, 0);
      full_cmp("80_01", 8'h80, 8'h01, 1);
      full_cmp("ff_fe", 8'hFF, 8'hFE, 1);
      full_cmp("00_ff", 8'h00, 8'hFF, 0);
      full_cmp("7f_80", 8'h7F, 8'h80, 2);

      // Abort after 4 bits; restart cycle carries a valid bit that must be ignored.
      begin_cmp(8'h00, 8'hFF, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(8'h00, 8'hFF, i, 0);
      chk_cnt("abort_pre_cnt", 4);
      void'(exp_q.pop_back());
      begin_cmp(8'h10, 8'h10, 1'b1);
      run_bits(8'h10, 8'h10, 1);
      check_fin("restart_eq");
      finish_idle("restart_eq");

      // Reset in the middle of a comparison.
      begin_cmp(8'h5A, 8'h3C, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(8'h5A, 8'h3C, i, 1);
      chk_cnt("midrst_pre_cnt", 5);
      void'(exp_q.pop_back());
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      hold_res = '0;
      chk("midrst_busy", 32'(w_busy), 32'h0);
      chk("midrst_done", 32'(w_done), 32'h0);
      chk("midrst_res", 32'(dut_res()), 32'h0);
      chk_cnt("midrst_cnt", 0);
      full_cmp("after_rst", 8'h5A, 8'h3C, 1);

      // START during FIN goes straight back to RUN.
      begin_cmp(8'hC3, 8'hC7, 1'b0);
      run_bits(8'hC3, 8'hC7, 0);
      check_fin("fin_start_a");
      begin_cmp(8'h01, 8'h02, 1'b0);
      run_bits(8'h01, 8'h02, 0);
      check_fin("fin_start_b");
      finish_idle("fin_start_b");

      for (int n = 0; n < 30; n++) begin
         ra = 8'($urandom);
         rb = (n % 5 == 0) ? ra : 8'($urandom);
         full_cmp("rand", ra, rb, 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
